// File: rtl/rocc_acc_mac.sv
// rocc_acc_mac: RoCC accumulator with clear, add, iterative MAC and read.
// The multiplier retires MulBitsPerCycle multiplier bits per MUL cycle.
module rocc_acc_mac #(
  parameter int XLEN            = 64,
  parameter int MulBitsPerCycle = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            rocc_cmd_valid_i,
  output logic            rocc_cmd_ready_o,
  input  logic [6:0]      rocc_cmd_funct_i,
  input  logic [XLEN-1:0] rocc_cmd_rs1_i,
  input  logic [XLEN-1:0] rocc_cmd_rs2_i,
  input  logic [4:0]      rocc_cmd_rd_i,
  input  logic            rocc_cmd_xd_i,
  output logic            rocc_resp_valid_o,
  input  logic            rocc_resp_ready_i,
  output logic [4:0]      rocc_resp_rd_o,
  output logic [XLEN-1:0] rocc_resp_data_o,
  output logic            rocc_busy_o
);

  localparam int MulCycles = XLEN / MulBitsPerCycle;
  localparam int CntW      = $clog2(MulCycles) + 1;
  localparam int PadW      = XLEN - MulBitsPerCycle;

  localparam logic [6:0] FunctClr = 7'd0;
  localparam logic [6:0] FunctAdd = 7'd1;
  localparam logic [6:0] FunctMac = 7'd2;
  localparam logic [6:0] FunctRd  = 7'd3;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   partial_q, partial_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              xd_q, xd_d;
  logic [4:0]        resp_rd_q, resp_rd_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;
  logic              resp_valid_q, resp_valid_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;

  logic              cmd_fire;
  logic              is_clr;
  logic              is_add;
  logic              is_mac;
  logic              is_rd;
  logic              mul_last;
  logic [XLEN-1:0]   pp;
  logic [XLEN-1:0]   partial_sum;

  assign rocc_cmd_ready_o  = cmd_ready_q;
  assign rocc_resp_valid_o = resp_valid_q;
  assign rocc_resp_rd_o    = resp_rd_q;
  assign rocc_resp_data_o  = resp_data_q;
  assign rocc_busy_o       = busy_q;

  assign cmd_fire = rocc_cmd_valid_i & cmd_ready_q;
  assign is_clr   = rocc_cmd_funct_i == FunctClr;
  assign is_add   = rocc_cmd_funct_i == FunctAdd;
  assign is_mac   = rocc_cmd_funct_i == FunctMac;
  assign is_rd    = rocc_cmd_funct_i == FunctRd;
  assign mul_last = cnt_q == CntW'(MulCycles - 1);

  // One radix-2^MulBitsPerCycle digit of the product per cycle.
  assign pp = mcand_q
            * {{PadW{1'b0}}, mplier_q[MulBitsPerCycle-1:0]};
  assign partial_sum = partial_q + pp;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    partial_d    = partial_q;
    cnt_d        = cnt_q;
    xd_d         = xd_q;
    resp_rd_d    = resp_rd_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          resp_rd_d = rocc_cmd_rd_i;
          xd_d      = rocc_cmd_xd_i;
          if (is_mac) begin
            mcand_d   = rocc_cmd_rs1_i;
            mplier_d  = rocc_cmd_rs2_i;
            partial_d = '0;
            cnt_d     = '0;
            state_d   = MUL;
          end else begin
            unique case (1'b1)
              is_clr: begin
                acc_d       = '0;
                resp_data_d = '0;
              end
              is_add: begin
                acc_d       = acc_q + rocc_cmd_rs1_i;
                resp_data_d = acc_d;
              end
              is_rd: begin
                resp_data_d = acc_q;
              end
              default: begin
                resp_data_d = '1;
              end
            endcase
            resp_valid_d = rocc_cmd_xd_i;
            state_d      = rocc_cmd_xd_i ? RESP : IDLE;
          end
        end
      end
      MUL: begin
        partial_d = partial_sum;
        mcand_d   = mcand_q << MulBitsPerCycle;
        mplier_d  = mplier_q >> MulBitsPerCycle;
        cnt_d     = cnt_q + CntW'(1);
        if (mul_last) begin
          acc_d        = acc_q + partial_sum;
          resp_data_d  = acc_d;
          resp_valid_d = xd_q;
          state_d      = xd_q ? RESP : IDLE;
        end
      end
      RESP: begin
        if (rocc_resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase

    // Registered decode of the next state keeps ready/busy input-free.
    cmd_ready_d = state_d == IDLE;
    busy_d      = state_d != IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      partial_q    <= '0;
      cnt_q        <= '0;
      xd_q         <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      partial_q    <= partial_d;
      cnt_q        <= cnt_d;
      xd_q         <= xd_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_rocc_acc_mac.sv
// tb_rocc_acc_mac: scoreboard bench for the RoCC accumulator.
// Expected responses are queued at command accept, checked on resp.
module tb_rocc_acc_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  funct;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [4:0]  cmd_rd;
  logic        cmd_xd;
  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_rd;
  logic [63:0] resp_data;
  logic        busy;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] acc_m;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rocc_acc_mac dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .rocc_cmd_valid_i  (cmd_valid),
    .rocc_cmd_ready_o  (cmd_ready),
    .rocc_cmd_funct_i  (funct),
    .rocc_cmd_rs1_i    (rs1),
    .rocc_cmd_rs2_i    (rs2),
    .rocc_cmd_rd_i     (cmd_rd),
    .rocc_cmd_xd_i     (cmd_xd),
    .rocc_resp_valid_o (resp_valid),
    .rocc_resp_ready_i (resp_ready),
    .rocc_resp_rd_o    (resp_rd),
    .rocc_resp_data_o  (resp_data),
    .rocc_busy_o       (busy)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [6:0]  f,
                       input logic [63:0] a,
                       input logic [63:0] b,
                       input logic [4:0]  rd,
                       input logic        xd);
    logic [63:0] d;
    logic [63:0] p;
    p = a * b;
    case (f)
      7'd0: begin acc_m = '0; d = '0; end
      7'd1: begin acc_m = acc_m + a; d = acc_m; end
      7'd2: begin acc_m = acc_m + p; d = acc_m; end
      7'd3: d = acc_m;
      default: d = '1;
    endcase
    if (xd) sb.push_back('{rd: rd, data: d});
  endtask

  // Returns #1 after the accepting edge.
  task automatic send(input logic [6:0]  f,
                      input logic [63:0] a,
                      input logic [63:0] b,
                      input logic [4:0]  rd,
                      input logic        xd);
    int n;
    cmd_valid = 1'b1;
    funct     = f;
    rs1       = a;
    rs2       = b;
    cmd_rd    = rd;
    cmd_xd    = xd;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_timeout", 64'd0, 64'd1);
    model(f, a, b, rd, xd);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", 64'd1, 64'd0);
      end else begin
        check("resp_rd", 64'(resp_rd), 64'(sb[0].rd));
        check("resp_data", resp_data, sb[0].data);
        if (resp_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    int n;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    funct      = '0;
    rs1        = '0;
    rs2        = '0;
    cmd_rd     = '0;
    cmd_xd     = 1'b0;
    resp_ready = 1'b1;
    acc_m      = '0;
    step(3);
    rst = 1'b0;
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd", 64'(resp_rd), 64'd0);
    check("rst_data", resp_data, 64'd0);

    send(7'd3, 64'd0, 64'd0, 5'd5, 1'b1);
    check("rd_lat_valid", 64'(resp_valid), 64'd1);
    check("rd_lat_ready", 64'(cmd_ready), 64'd0);
    step(1);
    check("hs_ready", 64'(cmd_ready), 64'd1);
    check("hs_valid", 64'(resp_valid), 64'd0);

    send(7'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd1, 1'b1);
    send(7'd1, 64'd2, 64'd0, 5'd2, 1'b1);

    send(7'd0, 64'd0, 64'd0, 5'd3, 1'b1);
    send(7'd2, 64'd3, 64'h1_0000_0001, 5'd4, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check("mac_busy", 64'(busy), 64'd1);
      check("mac_nvalid", 64'(resp_valid), 64'd0);
      step(1);
    end
    check("mac_lat_valid", 64'(resp_valid), 64'd1);
    send(7'd2, 64'd3, 64'h1_0000_0001, 5'd6, 1'b1);

    // Back-pressure with a queued ADD held on the command port.
    send(7'd2, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F, 5'd7, 1'b1);
    cmd_valid  = 1'b1;
    funct      = 7'd1;
    rs1        = 64'd7;
    rs2        = '0;
    cmd_rd     = 5'd8;
    cmd_xd     = 1'b0;
    resp_ready = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin
      step(1);
      n++;
    end
    check("bp_valid", 64'(resp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_ready_low", 64'(cmd_ready), 64'd0);
      check("bp_hold", 64'(resp_valid), 64'd1);
      step(1);
    end
    resp_ready = 1'b1;
    step(1);
    check("bp_hs_valid", 64'(resp_valid), 64'd0);
    check("bp_hs_ready", 64'(cmd_ready), 64'd1);
    send(7'd1, 64'd7, 64'd0, 5'd8, 1'b0);
    send(7'd3, 64'd0, 64'd0, 5'd9, 1'b1);

    send(7'd0, 64'd0, 64'd0, 5'd10, 1'b0);
    send(7'd1, 64'd10, 64'd0, 5'd11, 1'b0);
    send(7'd3, 64'd0, 64'd0, 5'd12, 1'b1);
    send(7'd9, 64'd0, 64'd0, 5'd13, 1'b1);
    send(7'd3, 64'd0, 64'd0, 5'd14, 1'b1);

    for (int i = 0; i < 4; i++) begin
      send(7'd2, {$urandom, $urandom}, {$urandom, $urandom},
           5'(16 + i), 1'($urandom_range(0, 1)));
    end
    send(7'd3, 64'd0, 64'd0, 5'd20, 1'b1);

    // Reset during the 8th MUL cycle drops the pending MAC.
    send(7'd2, 64'd5, 64'd6, 5'd21, 1'b1);
    step(7);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    sb.delete();
    acc_m = '0;
    check("mrst_ready", 64'(cmd_ready), 64'd1);
    check("mrst_valid", 64'(resp_valid), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    send(7'd3, 64'd0, 64'd0, 5'd22, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step(1);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
